sr_input_conditioner: RTL
=========================

// Module: sr_input_conditioner
// PURPOSE
//   Conditions two raw asynchronous requests (set_raw, reset_raw) into clean s/r drive for srFF.
//   - Synchronises and debounces both requests.
//   - Arbitrates so s and r are never high together; the srFF forbidden state is unreachable.
//   - Flags and counts conflicting requests. Sits directly upstream of srFF: s -> srFF.s, r -> srFF.r.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive stable cycles before a synced input is accepted (>=1)
//   PULSE_MODE       0   0: s/r are levels held while request active; 1: one-cycle pulse on entry
//   CNT_W            8   width of conflict_cnt (saturating)
// PORTS
//   clk           in   1      single clock, all logic on rising edge
//   rst           in   1      asynchronous, active-high reset
//   set_raw       in   1      raw set request, asynchronous to clk
//   reset_raw     in   1      raw reset request, asynchronous to clk
//   s             out  1      registered set drive to srFF
//   r             out  1      registered reset drive to srFF
//   conflict      out  1      high while in CONFLICT state
//   conflict_cnt  out  CNT_W  number of CONFLICT entries, saturates at all-ones
// BEHAVIOUR
//   Reset: s=0, r=0, conflict=0, conflict_cnt=0, state=IDLE; sync flops, debounced values and counters cleared.
//   Sync: two-flop synchroniser per input.
//   Debounce, per channel:
//     - Counter increments each cycle the sync output differs from the debounced value.
//     - Counter clears whenever they agree (glitch restarts the count).
//     - At DEBOUNCE_CYCLES the debounced value takes the new level and the counter clears.
//   Latency: raw edge held stable -> debounced updates at edge 2+DEBOUNCE_CYCLES -> s/r update at edge
//     3+DEBOUNCE_CYCLES (edge 1 = first edge sampling the new raw level). Same latency for deassertion.
//   FSM inputs: ds, dr (debounced). States and transitions, evaluated every edge:
//     IDLE:     ds&dr -> CONFLICT; ds -> SET; dr -> RESET; else stay
//     SET:      dr (with or without ds) -> CONFLICT; !ds -> IDLE; else stay
//     RESET:    ds (with or without dr) -> CONFLICT; !dr -> IDLE; else stay
//     CONFLICT: !ds&!dr -> IDLE; otherwise stay (must fully release both before any new command)
//   Outputs, registered from next state:
//     - PULSE_MODE=0: s=(state==SET), r=(state==RESET).
//     - PULSE_MODE=1: s high only on the cycle SET is entered, r only on the cycle RESET is entered.
//     - conflict=(state==CONFLICT).
//     - s and r are never 1 on the same cycle, in any state or mode.
//   conflict_cnt: +1 on each transition into CONFLICT; holds at 2^CNT_W-1; cleared only by rst.
//   Reset mid-operation: outputs drop to 0 asynchronously. Debounce restarts from 0, so a request still
//     held after rst release is re-accepted after the full 3+DEBOUNCE_CYCLES latency.
//   Simultaneous debounced rise of ds and dr on the same edge: IDLE -> CONFLICT, never SET or RESET.
// TESTING (DEBOUNCE_CYCLES=4, PULSE_MODE=0 unless stated)
//   1. rst=1 for 3 cycles, raw inputs at 0 -> s=r=conflict=0, conflict_cnt=0 throughout.
//   2. set_raw 0->1 held -> s=1 at edge 7 and not before, r=0; set_raw->0 -> s=0 seven edges later.
//   3. set_raw high 3 cycles then low (glitch) -> s stays 0; debounce counter observed back at 0.
//   4. SET active, then reset_raw held high -> conflict=1, s=r=0, conflict_cnt=1; release both -> IDLE.
//      Then reset_raw alone -> r=1.
//   5. PULSE_MODE=1, set_raw held 20 cycles -> s high exactly 1 cycle at edge 7; r never high.
//   6. rst pulsed while s=1 with set_raw still high -> s=0 immediately; s=1 again 7 edges after rst release.
//      Separately, force 300 conflicts -> conflict_cnt saturates at 255.

Source files
------------

// File: rtl/sr_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sr_input_conditioner
// Description : Synchronises, debounces and arbitrates raw set/reset requests
//               into mutually exclusive s/r drive for a downstream srFF.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit PULSE_MODE      = 1'b0,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_raw,
  input  logic             reset_raw,
  output logic             s,
  output logic             r,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET      = 2'd1,
    RESET    = 2'd2,
    CONFLICT = 2'd3
  } state_t;

  // Channel index 0 carries set, index 1 carries reset.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  state_t          state_q, state_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            conflict_q, conflict_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic ds, dr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {reset_raw, set_raw};
      sync2_q <= sync1_q;
    end
  end

  // Any cycle of agreement restarts the count, so only an unbroken run of
  // DEBOUNCE_CYCLES disagreeing samples moves the debounced level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q        <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign ds = db_q[0];
  assign dr = db_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ds && dr)  state_d = CONFLICT;
        else if (ds)   state_d = SET;
        else if (dr)   state_d = RESET;
      end
      SET: begin
        if (dr)        state_d = CONFLICT;
        else if (!ds)  state_d = IDLE;
      end
      RESET: begin
        if (ds)        state_d = CONFLICT;
        else if (!dr)  state_d = IDLE;
      end
      CONFLICT: begin
        if (!ds && !dr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_comb begin
    if (PULSE_MODE) begin
      s_d = (state_d == SET)   && (state_q != SET);
      r_d = (state_d == RESET) && (state_q != RESET);
    end else begin
      s_d = (state_d == SET);
      r_d = (state_d == RESET);
    end
    conflict_d     = (state_d == CONFLICT);
    conflict_cnt_d = conflict_cnt_q;
    if ((state_d == CONFLICT) && (state_q != CONFLICT) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      r_q            <= r_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign s            = s_q;
  assign r            = r_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
`default_nettype wire
